data_cache: RTL and testbench

Direct-mapped, write-back, write-allocate data cache between the processor's memory stage and a line-wide main memory. The memory stage presents its read/write command, byte flag, ALU-computed address and store data; the cache answers hits in the same cycle. On a miss it raises `stall` to freeze the pipeline and runs a write-back/refill sequence over a request/ready memory handshake. The memory is modelled with a 5-cycle access latency.

---
 rtl/data_cache_if.sv | 19 +
 rtl/data_cache.sv | 158 +++++++++++++++
 tb/tb_data_cache.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/data_cache_if.sv
// Line-wide memory handshake between the data cache (master) and main memory (slave).
interface data_cache_if;
   logic         mem_req;
   logic         mem_we;
   logic [27:0]  mem_addr;
   logic [127:0] mem_wdata;
   logic [127:0] mem_rdata;
   logic         mem_ready;

   modport master (
      output mem_req, mem_we, mem_addr, mem_wdata,
      input  mem_rdata, mem_ready
   );

   modport slave (
      input  mem_req, mem_we, mem_addr, mem_wdata,
      output mem_rdata, mem_ready
   );
endinterface

// File: rtl/data_cache.sv
// Direct-mapped, write-back, write-allocate data cache with 128-bit lines.
// Hits complete in the same cycle; misses stall the pipeline while the
// victim is written back (if dirty) and the line is refilled.
// Optional feature: define DCACHE_STATS_EN to add saturating hit/miss counters.
module data_cache #(
   parameter int unsigned LINES = 4
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        read_cmd,
   input  logic        write_cmd,
   input  logic        byte_access,
   input  logic [31:0] address,
   input  logic [31:0] write_data,
   output logic [31:0] read_data,
   output logic        stall,
`ifdef DCACHE_STATS_EN
   output logic [31:0] hit_count,
   output logic [31:0] miss_count,
`endif
   data_cache_if.master mem
);

   localparam int unsigned IW = $clog2(LINES);
   localparam int unsigned TW = 28 - IW;

   typedef enum logic [1:0] {IDLE, WRITEBACK, FILL} state_t;

   state_t            state;
   logic [LINES-1:0]  valid_q;
   logic [LINES-1:0]  dirty_q;
   logic [TW-1:0]     tag_q  [LINES];
   logic [127:0]      data_q [LINES];
   logic [27:0]       miss_line;
   logic              pending;

   logic              cmd;
   logic              hit;
   logic              wr_hit;
   logic              fill_done;
   logic [IW-1:0]     idx;
   logic [IW-1:0]     miss_idx;
   logic [TW-1:0]     tag_in;
   logic [1:0]        word_sel;
   logic [1:0]        byte_sel;
   logic [31:0]       word_rd;
   logic [7:0]        byte_rd;

   // Address decode and hit detection against the indexed line.
   assign cmd       = read_cmd | write_cmd;
   assign idx       = address[3+IW:4];
   assign tag_in    = address[31:4+IW];
   assign word_sel  = address[3:2];
   assign byte_sel  = address[1:0];
   assign miss_idx  = miss_line[IW-1:0];
   assign hit       = cmd && valid_q[idx] && (tag_q[idx] == tag_in) && (state == IDLE);
   assign wr_hit    = hit && write_cmd;
   assign fill_done = (state == FILL) && mem.mem_ready;
   assign stall     = reset && ((state != IDLE) || (cmd && !hit));
   assign word_rd   = data_q[idx][{word_sel, 5'b00000} +: 32];
   assign byte_rd   = word_rd[{byte_sel, 3'b000} +: 8];

   // Load result: selected word, or zero-extended byte, only on a read hit.
   always_comb begin
      read_data = '0;
      if (hit && !write_cmd) begin
         read_data = byte_access ? {24'h000000, byte_rd} : word_rd;
      end
   end

   // Line data and tag storage: refill overwrites the line, store hits patch it.
   always_ff @(posedge clock) begin
      if (fill_done) begin
         data_q[miss_idx] <= mem.mem_rdata;
         tag_q[miss_idx]  <= miss_line[27:IW];
      end else if (wr_hit) begin
         if (byte_access) begin
            data_q[idx][{word_sel, byte_sel, 3'b000} +: 8] <= write_data[7:0];
         end else begin
            data_q[idx][{word_sel, 5'b00000} +: 32] <= write_data;
         end
      end
   end

   // Miss FSM with registered memory request, plus valid/dirty bookkeeping.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state         <= IDLE;
         valid_q       <= '0;
         dirty_q       <= '0;
         miss_line     <= '0;
         pending       <= 1'b0;
         mem.mem_req   <= 1'b0;
         mem.mem_we    <= 1'b0;
         mem.mem_addr  <= '0;
         mem.mem_wdata <= '0;
`ifdef DCACHE_STATS_EN
         hit_count     <= '0;
         miss_count    <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (wr_hit) begin
                  dirty_q[idx] <= 1'b1;
               end
               if (hit) begin
                  pending <= 1'b0;
`ifdef DCACHE_STATS_EN
                  if (!pending && (hit_count != 32'hFFFF_FFFF)) begin
                     hit_count <= hit_count + 32'd1;
                  end
`endif
               end else if (cmd) begin
                  miss_line   <= address[31:4];
                  pending     <= 1'b1;
                  mem.mem_req <= 1'b1;
`ifdef DCACHE_STATS_EN
                  if (miss_count != 32'hFFFF_FFFF) begin
                     miss_count <= miss_count + 32'd1;
                  end
`endif
                  if (valid_q[idx] && dirty_q[idx]) begin
                     state         <= WRITEBACK;
                     mem.mem_we    <= 1'b1;
                     mem.mem_addr  <= {tag_q[idx], idx};
                     mem.mem_wdata <= data_q[idx];
                  end else begin
                     state        <= FILL;
                     mem.mem_we   <= 1'b0;
                     mem.mem_addr <= address[31:4];
                     valid_q[idx] <= 1'b0;
                  end
               end
            end
            WRITEBACK: begin
               if (mem.mem_ready) begin
                  state             <= FILL;
                  dirty_q[miss_idx] <= 1'b0;
                  valid_q[miss_idx] <= 1'b0;
                  mem.mem_we        <= 1'b0;
                  mem.mem_addr      <= miss_line;
               end
            end
            FILL: begin
               if (mem.mem_ready) begin
                  state             <= IDLE;
                  valid_q[miss_idx] <= 1'b1;
                  dirty_q[miss_idx] <= 1'b0;
                  mem.mem_req       <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_data_cache.sv
// Directed bench for data_cache: 5-cycle memory responder, hit/miss timing,
// byte/word access, write-back of a dirty victim and reset during a fill.
module tb_data_cache;

   logic        clock;
   logic        reset;
   logic        read_cmd;
   logic        write_cmd;
   logic        byte_access;
   logic [31:0] address;
   logic [31:0] write_data;
   logic [31:0] read_data;
   logic        stall;
`ifdef DCACHE_STATS_EN
   logic [31:0] hit_count;
   logic [31:0] miss_count;
`endif

   data_cache_if bus ();

   data_cache #(.LINES(4)) dut (
      .clock       (clock),
      .reset       (reset),
      .read_cmd    (read_cmd),
      .write_cmd   (write_cmd),
      .byte_access (byte_access),
      .address     (address),
      .write_data  (write_data),
      .read_data   (read_data),
      .stall       (stall),
`ifdef DCACHE_STATS_EN
      .hit_count   (hit_count),
      .miss_count  (miss_count),
`endif
      .mem         (bus)
   );

   int n_tests = 0;
   int n_fail  = 0;

   logic [27:0]  fill_addr;
   logic [27:0]  wb_addr;
   logic [127:0] wb_data;
   logic         wb_seen;

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Main memory contents for the lines this bench touches.
   function automatic logic [127:0] line_of(input logic [27:0] a);
      case (a)
         28'h0000004: line_of = 128'h33332222_11110000_DDDDCCCC_BBBBAAAA;
         28'h0000008: line_of = 128'h88887777_66665555_44443333_22221111;
         28'h000000C: line_of = 128'hFFFFEEEE_DDDDCCCC_BBBBAAAA_99998888;
         default:     line_of = '0;
      endcase
   endfunction

   // Memory responder: ready in the 5th cycle of each request.
   initial begin
      int cnt;
      cnt           = 0;
      bus.mem_ready = 1'b0;
      bus.mem_rdata = '0;
      fill_addr     = '0;
      wb_addr       = '0;
      wb_data       = '0;
      wb_seen       = 1'b0;
      forever begin
         @(negedge clock);
         if (bus.mem_req) begin
            cnt = (bus.mem_ready ? 0 : cnt) + 1;
         end else begin
            cnt = 0;
         end
         bus.mem_ready = bus.mem_req && (cnt == 5);
         bus.mem_rdata = line_of(bus.mem_addr);
         if (bus.mem_ready) begin
            if (bus.mem_we) begin
               wb_seen = 1'b1;
               wb_addr = bus.mem_addr;
               wb_data = bus.mem_wdata;
            end else begin
               fill_addr = bus.mem_addr;
            end
         end
      end
   end

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Issue one access starting at posedge+1, hold it until stall drops.
   task automatic do_access(input logic rd, input logic wr, input logic bt,
                            input logic [31:0] addr, input logic [31:0] wd,
                            output int cyc, output logic [31:0] rdata);
      bit done;
      read_cmd    = rd;
      write_cmd   = wr;
      byte_access = bt;
      address     = addr;
      write_data  = wd;
      cyc         = 0;
      rdata       = '0;
      done        = 1'b0;
      for (int i = 0; i < 40 && !done; i++) begin
         @(negedge clock);
         if (!stall) begin
            rdata = read_data;
            done  = 1'b1;
         end else begin
            cyc++;
         end
      end
      if (!done) begin
         n_tests++;
         n_fail++;
         $display("FAIL timeout: access %0h still stalled after 40 cycles", addr);
      end
      @(posedge clock);
      #1;
      read_cmd  = 1'b0;
      write_cmd = 1'b0;
   endtask

   initial begin
      int          cyc;
      logic [31:0] rd;

      reset       = 1'b0;
      read_cmd    = 1'b0;
      write_cmd   = 1'b0;
      byte_access = 1'b0;
      address     = '0;
      write_data  = '0;
      #12;
      check("rst_read_data", 128'(read_data),     128'h0);
      check("rst_stall",     128'(stall),         128'h0);
      check("rst_mem_req",   128'(bus.mem_req),   128'h0);
      check("rst_mem_we",    128'(bus.mem_we),    128'h0);
      check("rst_mem_addr",  128'(bus.mem_addr),  128'h0);
      check("rst_mem_wdata", bus.mem_wdata,       128'h0);
      @(negedge clock);
      reset = 1'b1;
      @(posedge clock);
      #1;

      // Clean miss: 6 stall cycles, fill of line 0x4.
      do_access(1'b1, 1'b0, 1'b0, 32'h0000_0040, 32'h0, cyc, rd);
      check("miss_stall", 128'(cyc), 128'd6);
      check("miss_fill_addr", 128'(fill_addr), 128'h4);
      check("miss_rdata", 128'(rd), 128'hBBBBAAAA);

      // Byte read hit.
      do_access(1'b1, 1'b0, 1'b1, 32'h0000_0045, 32'h0, cyc, rd);
      check("byte_rd_stall", 128'(cyc), 128'd0);
      check("byte_rd_data", 128'(rd), 128'h000000CC);

      // Byte write hit, then word read sees the merged byte.
      do_access(1'b0, 1'b1, 1'b1, 32'h0000_0042, 32'h1234_56EF, cyc, rd);
      check("byte_wr_stall", 128'(cyc), 128'd0);
      do_access(1'b1, 1'b0, 1'b0, 32'h0000_0040, 32'h0, cyc, rd);
      check("word_rd_stall", 128'(cyc), 128'd0);
      check("word_rd_merged", 128'(rd), 128'hBBEFAAAA);

      // Conflicting miss on dirty line: write-back then fill, 11 stall cycles.
      do_access(1'b1, 1'b0, 1'b0, 32'h0000_0080, 32'h0, cyc, rd);
      check("dirty_stall", 128'(cyc), 128'd11);
      check("wb_seen", 128'(wb_seen), 128'h1);
      check("wb_addr", 128'(wb_addr), 128'h4);
      check("wb_data", wb_data, 128'h33332222_11110000_DDDDCCCC_BBEFAAAA);
      check("dirty_fill_addr", 128'(fill_addr), 128'h8);
      check("dirty_rdata", 128'(rd), 128'h22221111);

      // Hit on another word of the new line.
      do_access(1'b1, 1'b0, 1'b0, 32'h0000_0084, 32'h0, cyc, rd);
      check("hit2_stall", 128'(cyc), 128'd0);
      check("hit2_rdata", 128'(rd), 128'h44443333);

`ifdef DCACHE_STATS_EN
      check("miss_count", 128'(miss_count), 128'd2);
      check("hit_count", 128'(hit_count), 128'd4);
`endif

      // Clean miss to line 0xC, reset pulse in the middle of the fill.
      read_cmd = 1'b1;
      address  = 32'h0000_00C0;
      repeat (3) @(negedge clock);
      check("fill_mem_req", 128'(bus.mem_req), 128'h1);
      check("fill_mem_we", 128'(bus.mem_we), 128'h0);
      check("fill_mem_addr", 128'(bus.mem_addr), 128'hC);
      #1;
      reset    = 1'b0;
      read_cmd = 1'b0;
      #1;
      check("abort_mem_req", 128'(bus.mem_req), 128'h0);
      check("abort_stall", 128'(stall), 128'h0);
      @(negedge clock);
      reset = 1'b1;
      @(posedge clock);
      #1;

      // Re-read misses again (line left invalid) and completes.
      do_access(1'b1, 1'b0, 1'b0, 32'h0000_00C0, 32'h0, cyc, rd);
      check("reread_stall", 128'(cyc), 128'd6);
      check("reread_fill_addr", 128'(fill_addr), 128'hC);
      check("reread_rdata", 128'(rd), 128'h99998888);

      // Idle: no command gives zero data and no stall.
      @(negedge clock);
      check("idle_read_data", 128'(read_data), 128'h0);
      check("idle_stall", 128'(stall), 128'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
